// File: rtl/ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// ahb_lite_interconnect
//
// Single-master AHB-Lite decoder and response multiplexer with an internal
// default slave that answers unmapped NONSEQ/SEQ transfers with a two-cycle
// ERROR response.
//
// Address map: haddr[REGION_LSB+2:REGION_LSB] is the slave index. It selects
// that slave when the index is below NUM_SLAVES and every address bit above
// the index field is zero. Anything else goes to the default slave.
//
// Optional feature (macro AHB_IC_TIMEOUT_EN): a wait-state watchdog. Once a
// slave has held off an active transfer for TIMEOUT_CYC cycles, the
// interconnect takes over and returns the same two-cycle ERROR response.
// Without the macro, slave wait states pass through unbounded.
//
// Ports
//   hclk, hreset          clock; asynchronous active-high reset
//   haddr, htrans         master address phase
//   hready, hresp, hrdata response to master (hready also feeds the slaves)
//   hsel_s                one-hot address-phase slave select (combinational)
//   hreadyout_s, hresp_s  per-slave ready / response
//   hrdata_s              per-slave read data, slave i at [i*DATA_W +: DATA_W]
//   err_pulse             high on the first cycle of an interconnect ERROR
// ---------------------------------------------------------------------------
module ahb_lite_interconnect #(
  parameter int NUM_SLAVES  = 4,
  parameter int DATA_W      = 32,
  parameter int REGION_LSB  = 28,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [31:0]                  haddr,
  input  logic [1:0]                   htrans,
  output logic                         hready,
  output logic                         hresp,
  output logic [DATA_W-1:0]            hrdata,
  output logic [NUM_SLAVES-1:0]        hsel_s,
  input  logic [NUM_SLAVES-1:0]        hreadyout_s,
  input  logic [NUM_SLAVES-1:0]        hresp_s,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
  output logic                         err_pulse
);

  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;

  // ---------------- address decode ----------------
  logic [31:0] addr_shift;
  logic [2:0]  idx;
  logic        addr_def;

  assign addr_shift = haddr >> REGION_LSB;
  assign idx        = addr_shift[2:0];
  assign addr_def   = !((addr_shift[31:3] == '0) &&
                        ({29'd0, idx} < 32'(NUM_SLAVES)));

  // ---------------- data-phase registers ----------------
  logic [2:0]            dsel_reg;
  logic                  ddef_reg;
  logic [NUM_SLAVES-1:0] dsel_oh;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
      assign hsel_s[gi]  = !addr_def && (idx == 3'(gi));
      assign dsel_oh[gi] = !ddef_reg && (dsel_reg == 3'(gi));
    end
  endgenerate

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dsel_reg <= '0;
      ddef_reg <= 1'b1;
    end else if (hready) begin
      dsel_reg <= idx;
      ddef_reg <= addr_def;
    end
  end

  // ---------------- slave response mux ----------------
  logic              slave_ready;
  logic              slave_resp;
  logic [DATA_W-1:0] slave_rdata;

  assign slave_ready = |(dsel_oh & hreadyout_s);
  assign slave_resp  = |(dsel_oh & hresp_s);

  always_comb begin
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_oh[i]) slave_rdata = hrdata_s[i*DATA_W +: DATA_W];
    end
  end

  // ---------------- default-slave FSM ----------------
  state_t state_reg;
  logic   def_ready_reg;
  logic   def_resp_reg;
  logic   err_pulse_reg;
  logic   use_slave;
  logic   timeout_fire;
  logic   go_err1;

  // The slave only owns the response while the FSM is idle; an ERROR
  // sequence (decode or timeout) always overrides routing.
  assign use_slave = (state_reg == ST_OK) && !ddef_reg;

  assign hready    = use_slave ? slave_ready : def_ready_reg;
  assign hresp     = use_slave ? slave_resp  : def_resp_reg;
  assign hrdata    = use_slave ? slave_rdata : '0;
  assign err_pulse = err_pulse_reg;

  // Decode error: an active transfer to the default slave is being accepted.
  // ERR1 holds hready low, so no acceptance can happen there.
  assign go_err1 = timeout_fire ||
                   ((state_reg != ST_ERR1) && hready && addr_def && htrans[1]);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_reg     <= ST_OK;
      def_ready_reg <= 1'b1;
      def_resp_reg  <= 1'b0;
      err_pulse_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_ERR1: begin
          state_reg     <= ST_ERR2;
          def_ready_reg <= 1'b1;
          def_resp_reg  <= 1'b1;
          err_pulse_reg <= 1'b0;
        end
        default: begin
          if (go_err1) begin
            state_reg     <= ST_ERR1;
            def_ready_reg <= 1'b0;
            def_resp_reg  <= 1'b1;
            err_pulse_reg <= 1'b1;
          end else begin
            state_reg     <= ST_OK;
            def_ready_reg <= 1'b1;
            def_resp_reg  <= 1'b0;
            err_pulse_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------- optional wait-state watchdog ----------------
`ifdef AHB_IC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic             dactive_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             slave_wait;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dactive_reg <= 1'b0;
    end else if (hready) begin
      dactive_reg <= htrans[1];
    end
  end

  assign slave_wait = dactive_reg && use_slave && !slave_ready;
  // Fire on the last permitted wait cycle so the ERROR follows immediately
  // after exactly TIMEOUT_CYC slave wait states.
  assign timeout_fire = slave_wait && (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wait_cnt_reg <= '0;
    end else if (hready || timeout_fire) begin
      wait_cnt_reg <= '0;
    end else if (slave_wait) begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end
`else
  logic unused_cfg;

  assign timeout_fire = 1'b0;
  assign unused_cfg   = (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_interconnect
//
// Acts as both master and slaves. Each transfer is described at transaction
// level (target, wait states, data, response); the expected response of every
// data-phase cycle follows from that description and the address map.
// Directed scenarios come first, then randomized transfers.
// ---------------------------------------------------------------------------
module tb_ahb_lite_interconnect;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic             hclk = 1'b0;
  logic             hreset;
  logic [31:0]      haddr;
  logic [1:0]       htrans;
  logic             hready;
  logic             hresp;
  logic [DW-1:0]    hrdata;
  logic [NS-1:0]    hsel_s;
  logic [NS-1:0]    hreadyout_s;
  logic [NS-1:0]    hresp_s;
  logic [NS*DW-1:0] hrdata_s;
  logic             err_pulse;

  int checks = 0;
  int errors = 0;

  ahb_lite_interconnect #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .REGION_LSB (28),
    .TIMEOUT_CYC(TO)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .haddr      (haddr),
    .htrans     (htrans),
    .hready     (hready),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .hsel_s     (hsel_s),
    .hreadyout_s(hreadyout_s),
    .hresp_s    (hresp_s),
    .hrdata_s   (hrdata_s),
    .err_pulse  (err_pulse)
  );

  always #5 hclk = ~hclk;

  // Pending address phase (what the master drives now).
  logic [31:0] a_addr;
  logic [1:0]  a_trans;
  int          a_waits;
  logic [31:0] a_data;
  logic        a_resp;

  // Current data phase: kind 0 = OKAY from interconnect, 1 = routed slave,
  // 2 = interconnect ERROR (err_step 0 first cycle, 1 second cycle).
  int          dp_kind;
  int          dp_slave;
  int          dp_waits;
  int          dp_waited;
  int          dp_err_step;
  logic [31:0] dp_data;
  logic        dp_resp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected one-hot select straight from the address map: region = top nibble.
  function automatic logic [31:0] exp_hsel(input logic [31:0] a);
    int region;
    region = int'(a[31:28]);
    return (region < NS) ? (32'd1 << region) : 32'd0;
  endfunction

  // One bus cycle: drive at the falling edge, check 1 ns later, advance the
  // model on the rising edge, return at the next falling edge.
  task automatic step(output bit accepted);
    logic        e_ready, e_resp, e_pulse;
    logic [31:0] e_rdata;
    haddr  = a_addr;
    htrans = a_trans;
    for (int i = 0; i < NS; i++) begin
      hreadyout_s[i]        = 1'($urandom_range(0, 1));
      hresp_s[i]            = 1'($urandom_range(0, 1));
      hrdata_s[i*DW +: DW]  = $urandom;
    end
    if (dp_kind == 1) begin
      hreadyout_s[dp_slave]       = (dp_waits == 0);
      hresp_s[dp_slave]           = dp_resp;
      hrdata_s[dp_slave*DW +: DW] = dp_data;
    end
    #1;
    if (dp_kind == 1) begin
      e_ready = (dp_waits == 0);
      e_resp  = dp_resp;
      e_rdata = dp_data;
      e_pulse = 1'b0;
    end else if (dp_kind == 2) begin
      e_ready = (dp_err_step == 1);
      e_resp  = 1'b1;
      e_rdata = 32'd0;
      e_pulse = (dp_err_step == 0);
    end else begin
      e_ready = 1'b1;
      e_resp  = 1'b0;
      e_rdata = 32'd0;
      e_pulse = 1'b0;
    end
    chk("hsel_s",    32'(hsel_s),    exp_hsel(a_addr));
    chk("hready",    32'(hready),    32'(e_ready));
    chk("hresp",     32'(hresp),     32'(e_resp));
    chk("hrdata",    hrdata,         e_rdata);
    chk("err_pulse", 32'(err_pulse), 32'(e_pulse));
    @(posedge hclk);
    if (e_ready) begin
      if (exp_hsel(a_addr) != 32'd0) begin
        dp_kind   = 1;
        dp_slave  = int'(a_addr[31:28]);
        dp_waited = 0;
        if (a_trans[1]) begin
          dp_waits = a_waits;
          dp_data  = a_data;
          dp_resp  = a_resp;
        end else begin
          dp_waits = 0;
          dp_data  = $urandom;
          dp_resp  = 1'b0;
        end
      end else begin
        dp_kind     = a_trans[1] ? 2 : 0;
        dp_err_step = 0;
      end
    end else if (dp_kind == 1) begin
      dp_waits--;
      dp_waited++;
`ifdef AHB_IC_TIMEOUT_EN
      if (dp_waited == TO) begin
        dp_kind     = 2;
        dp_err_step = 0;
      end
`endif
    end else if (dp_kind == 2) begin
      dp_err_step++;
    end
    accepted = e_ready;
    @(negedge hclk);
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic [1:0] trans, input int waits,
                        input logic [31:0] data, input logic resp);
    bit acc;
    int n;
    a_addr  = addr;
    a_trans = trans;
    a_waits = waits;
    a_data  = data;
    a_resp  = resp;
    $display("txn addr=0x%08h htrans=%0d waits=%0d data=0x%08h", addr, trans, waits, data);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      step(acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL accept_bound: address phase not accepted after %0d cycles, required acceptance", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int r;
    logic [31:0] addr;

    // Reset state (hsel_s is still a live decode).
    hreset      = 1'b1;
    a_addr      = 32'h2000_0000;
    a_trans     = 2'd0;
    a_waits     = 0;
    a_data      = 32'd0;
    a_resp      = 1'b0;
    dp_kind     = 0;
    dp_slave    = 0;
    dp_waits    = 0;
    dp_waited   = 0;
    dp_err_step = 0;
    dp_data     = 32'd0;
    dp_resp     = 1'b0;
    haddr       = 32'h2000_0000;
    htrans      = 2'd0;
    hreadyout_s = '0;
    hresp_s     = '1;
    hrdata_s    = '1;
    #12;
    chk("rst_hready",    32'(hready),    32'd1);
    chk("rst_hresp",     32'(hresp),     32'd0);
    chk("rst_hrdata",    hrdata,         32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_hsel_s",    32'(hsel_s),    32'h4);
    @(negedge hclk);
    hreset = 1'b0;

    // Directed scenarios.
    do_txn(32'h2000_0000, 2'd2, 0,  32'h1111_2222, 1'b0); // slave 2, zero wait
    do_txn(32'h1000_0004, 2'd2, 2,  32'hA5A5_0001, 1'b0); // slave 1, two waits
    do_txn(32'h9000_0000, 2'd2, 0,  32'd0,         1'b0); // unmapped NONSEQ
    do_txn(32'h9000_0000, 2'd0, 0,  32'd0,         1'b0); // unmapped IDLE in ERR2
    do_txn(32'h5000_0000, 2'd3, 0,  32'd0,         1'b0); // index >= NUM_SLAVES, SEQ
    do_txn(32'h0000_0000, 2'd1, 0,  32'd0,         1'b0); // BUSY to slave 0
    do_txn(32'h7000_0000, 2'd2, 0,  32'd0,         1'b0); // unmapped back-to-back
    do_txn(32'h8000_0000, 2'd3, 0,  32'd0,         1'b0);
    do_txn(32'h0000_0010, 2'd2, 20, 32'h0BAD_0BAD, 1'b0); // slave 0 long stall
    do_txn(32'h3000_0000, 2'd2, 5,  32'h3333_3333, 1'b1); // slave 3, five waits

    // Reset in the middle of slave 3's wait states.
    a_trans = 2'd0;
    step(acc);
    step(acc);
    #2;
    hreset = 1'b1;
    #1;
    chk("async_rst_hready", 32'(hready), 32'd1);
    chk("async_rst_hresp",  32'(hresp),  32'd0);
    chk("async_rst_hrdata", hrdata,      32'd0);
    @(negedge hclk);
    hreset  = 1'b0;
    dp_kind = 0;
    do_txn(32'h1000_0000, 2'd2, 1, 32'h1234_5678, 1'b0);

    // Randomized transfers.
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      addr = $urandom;
      addr[31:28] = (r < 8) ? 4'(r) : 4'($urandom_range(8, 15));
      do_txn(addr, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom,
             1'($urandom_range(0, 1)));
    end

    // Drain the final data phases.
    do_txn(32'h0000_0000, 2'd0, 0, 32'd0, 1'b0);
    do_txn(32'h0000_0000, 2'd0, 0, 32'd0, 1'b0);
    do_txn(32'h0000_0000, 2'd0, 0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
